// File: rtl/llc_set_fetch.sv
// llc_set_fetch: issues set reads to the LLC tag/state/evict-way SRAMs and queues the
// returned set data in a credit-controlled FIFO whose head feeds the lookup stage.
module llc_set_fetch #(
    parameter int WAYS       = 16,
    parameter int WAY_BITS   = 4,
    parameter int TAG_BITS   = 15,
    parameter int STATE_BITS = 3,
    parameter int SET_BITS   = 9,
    parameter int RD_LAT     = 2,
    parameter int DEPTH      = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    input  logic [SET_BITS-1:0]            req_set,
    output logic                           req_ready,
    input  logic                           flush,
    output logic                           rd_en,
    output logic [SET_BITS-1:0]            rd_set,
    input  logic [WAYS*TAG_BITS-1:0]       rd_tags,
    input  logic [WAYS*STATE_BITS-1:0]     rd_states,
    input  logic [WAY_BITS-1:0]            rd_evict_way,
    input  logic                           fifo_pop_lookup,
    output logic                           fifo_empty_lookup,
    output logic [WAYS*TAG_BITS-1:0]       tags_buf,
    output logic [WAYS*STATE_BITS-1:0]     states_buf,
    output logic [WAY_BITS-1:0]            evict_way_buf,
    output logic [SET_BITS-1:0]            set_buf
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int SUM_W  = CNT_W + 1;
    localparam int TW     = WAYS * TAG_BITS;
    localparam int SW     = WAYS * STATE_BITS;
    localparam int PIPE_W = RD_LAT * SET_BITS;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0]                 count_q, count_d;
    logic [CNT_W-1:0]                 inflight_q, inflight_d;
    logic [PTR_W-1:0]                 wptr_q, wptr_d;
    logic [PTR_W-1:0]                 rptr_q, rptr_d;
    logic [RD_LAT-1:0]                pipe_vld_q, pipe_vld_d;
    logic [RD_LAT-1:0][SET_BITS-1:0]  pipe_set_q, pipe_set_d;

    logic [TW-1:0]       tags_mem_q  [DEPTH];
    logic [SW-1:0]       states_mem_q[DEPTH];
    logic [WAY_BITS-1:0] evict_mem_q [DEPTH];
    logic [SET_BITS-1:0] set_mem_q   [DEPTH];

    logic accept;
    logic capture;
    logic pop;
    logic [SUM_W-1:0] credits_used;

    // Credits come from registered state only, so a pop frees its slot a cycle later.
    assign credits_used = {1'b0, count_q} + {1'b0, inflight_q};
    assign req_ready    = !flush && (credits_used < DEPTH_S);
    assign accept       = req_valid && req_ready;

    assign rd_en  = accept;
    assign rd_set = req_set;

    assign fifo_empty_lookup = (count_q == '0);
    assign capture           = pipe_vld_q[RD_LAT-1] && !flush;
    assign pop               = fifo_pop_lookup && !fifo_empty_lookup && !flush;

    assign tags_buf      = tags_mem_q[rptr_q];
    assign states_buf    = states_mem_q[rptr_q];
    assign evict_way_buf = evict_mem_q[rptr_q];
    assign set_buf       = set_mem_q[rptr_q];

    always_comb begin
        // Truncating cast shifts the new accept in at bit 0 and works for RD_LAT == 1.
        pipe_vld_d = RD_LAT'({pipe_vld_q, accept});
        pipe_set_d = PIPE_W'({pipe_set_q, req_set});
        count_d    = count_q + CNT_W'(capture) - CNT_W'(pop);
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(capture);
        wptr_d     = capture ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d     = pop ? rptr_q + PTR_W'(1) : rptr_q;
        if (flush) begin
            pipe_vld_d = '0;
            count_d    = '0;
            inflight_d = '0;
            wptr_d     = '0;
            rptr_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            inflight_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            pipe_vld_q <= '0;
            pipe_set_q <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_set_q <= pipe_set_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tags_mem_q[i]   <= '0;
                states_mem_q[i] <= '0;
                evict_mem_q[i]  <= '0;
                set_mem_q[i]    <= '0;
            end
        end else if (capture) begin
            tags_mem_q[wptr_q]   <= rd_tags;
            states_mem_q[wptr_q] <= rd_states;
            evict_mem_q[wptr_q]  <= rd_evict_way;
            set_mem_q[wptr_q]    <= pipe_set_q[RD_LAT-1];
        end
    end

    assert property (@(posedge clk) disable iff (!rst) count_q <= DEPTH_C)
        else $error("llc_set_fetch: FIFO count exceeds depth");

endmodule

// File: doc/llc_set_fetch.md
Name: llc_set_fetch

Overview:
- Producer end of the LLC lookup FIFO. Accepts set-read requests and issues reads to the LLC tag/state/evict-way SRAMs.
- Captures returned set data after a fixed SRAM latency and queues it in a small FIFO.
- The FIFO head drives the lookup stage's tags_buf, states_buf and evict_way_buf, plus fifo_empty_lookup; the lookup stage's fifo_pop_lookup dequeues the head.

Parameters:
- WAYS, 16, associativity.
- WAY_BITS, 4, log2(WAYS).
- TAG_BITS, 15, tag width.
- STATE_BITS, 3, per-way state width.
- SET_BITS, 9, set index width.
- RD_LAT, 2, SRAM read latency in cycles (1..4).
- DEPTH, 2, FIFO entries (power of 2, 2..8).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active low
- req_valid  in  1  set-read request valid
- req_set  in  SET_BITS  set index to read
- req_ready  out  1  request accepted when valid&&ready
- flush  in  1  synchronous drop of all queued and in-flight data
- rd_en  out  1  SRAM read strobe
- rd_set  out  SET_BITS  SRAM read address
- rd_tags  in  WAYS*TAG_BITS  SRAM tag data, way i at [i*TAG_BITS +: TAG_BITS]
- rd_states  in  WAYS*STATE_BITS  SRAM state data, same packing
- rd_evict_way  in  WAY_BITS  SRAM evict-way data
- fifo_pop_lookup  in  1  consumer dequeue
- fifo_empty_lookup  out  1  no head entry
- tags_buf  out  WAYS*TAG_BITS  head tags
- states_buf  out  WAYS*STATE_BITS  head states
- evict_way_buf  out  WAY_BITS  head evict way
- set_buf  out  SET_BITS  head set index

Behaviour:
- Reset values (rst low, async):
  - count=0, inflight=0, pointers=0, fifo_empty_lookup=1, req_ready=1, rd_en=0.
  - tags_buf, states_buf, evict_way_buf and set_buf read 0.
  - Reset mid-read discards the return; no entry appears after rst deasserts.
- Credit rule:
  - req_ready = !flush && (count + inflight < DEPTH), using registered count and inflight only.
  - A pop frees its credit one cycle later; there is no combinational pop-to-ready path.
- Accept cycle T: rd_en=1 and rd_set=req_set, combinational from accept. rd_en=0 when there is no accept.
- Latency tracking:
  - An RD_LAT-deep valid/set shift pipe records each accept.
  - Data on rd_* is sampled at the rising edge ending cycle T+RD_LAT and written to the tail.
  - fifo_empty_lookup falls in cycle T+RD_LAT+1.
- inflight: incremented on accept, decremented on capture; both in the same cycle leaves it unchanged.
- Pop:
  - fifo_pop_lookup && !fifo_empty_lookup advances the head at the edge.
  - A pop while empty is ignored: no pointer or count change.
- Simultaneous push and pop: count is unchanged and both pointers advance, including when count==DEPTH. Overflow is impossible by credit; an assertion checks count<=DEPTH.
- Head outputs: registered FIFO storage indexed by the read pointer, valid only when !fifo_empty_lookup. They are stable from push until pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Back-to-back accepts at one per cycle are allowed while credits remain.
- Flush (cycle F):
  - Next state is count=0, inflight=0, shift-pipe valids cleared, pointers reset.
  - The accept in cycle F is blocked (req_ready=0), as is any capture in cycle F.
  - A pop in cycle F has no effect beyond the flush.
- Ordering: entries leave in request order.

Test Plan:
- Single read, RD_LAT=2, DEPTH=2:
  - Stimulus: req_set=0x05 accepted at cycle 10; rd_tags way3=0x1234, rd_evict_way=7 at cycle 12.
  - Required: rd_en=1/rd_set=0x05 at cycle 10; fifo_empty_lookup=0 from cycle 13; set_buf=0x05, tags_buf way3=0x1234, evict_way_buf=7; pop at cycle 15 gives empty at cycle 16.
- Credit fill:
  - Stimulus: req_valid held high with no pops.
  - Required: two accepts (sets 1, 2) in consecutive cycles, then req_ready=0; a pop restores req_ready=1 the next cycle; the third entry is set 3.
- Simultaneous push and pop at count=1: count stays 1, head advances to the new set, no loss or duplicate across 8 wrap-around iterations.
- Pop when empty: fifo_pop_lookup=1 for 5 cycles at reset state; pointers and count stay 0 and no phantom entry appears.
- Flush with one entry queued and one in flight: fifo_empty_lookup=1 the next cycle, the later SRAM return is ignored, req_ready=1.
- Async reset asserted one cycle after an accept: all outputs return to reset values immediately; after release no entry appears and req_ready=1.
